melody_sequencer: RTL and testbench
===================================

# melody_sequencer

Plays a stored melody on the piezo tone generator by sequencing its `note` and `enable` inputs from a small programmable note table. Each entry holds a note code, a rest flag and a duration in beats. A short silent gap is inserted after every entry so that repeated notes stay audible as separate notes. Sits between the user/control logic and `piezoController`, on the same 1 MHz clock.

## Interface
- `DEPTH`, 16: number of table entries; `AW = $clog2(DEPTH)`.
- `BEAT_US`, 125000: clock cycles per beat (125 ms at 1 MHz).
- `GAP_US`, 10000: clock cycles of silence after each entry; 0 means no gap.
- `clk_1MHz` in 1: the single clock.
- `rst` in 1: reset, asynchronous and active-high.
- `wr_en` in 1: table write strobe.
- `wr_addr` in AW: table write address.
- `wr_data` in 8: entry format is [7] rest, [6:4] note, [3:0] duration in beats. Duration 0 is the end-of-song marker.
- `start` in 1: single-cycle pulse that begins playback at entry 0.
- `stop` in 1: single-cycle pulse that aborts playback.
- `loop_en` in 1: present only with `MELODY_LOOP_EN`.
- `note` out 3: note code to the piezo generator.
- `enable` out 1: enable to the piezo generator.
- `busy` out 1: high while playing.
- `done` out 1: one-cycle pulse on normal completion.
- `idx` out AW: index of the current entry.

## Operation
- Reset values: state IDLE; `note`, `enable`, `busy`, `done` and `idx` all 0. Table contents are not reset and are undefined until written.
- Table writes: a synchronous write happens whenever `wr_en` is high, in any state.
  - A write to the entry currently playing does not change the current note; it is used on the next fetch of that entry.
- States:
  - **IDLE**: `start` moves to FETCH with `idx` set to 0.
  - **FETCH** (1 cycle): latch the entry at `idx`.
    - If duration is non-zero, go to PLAY.
    - If duration is 0, the song ends (see end of song below).
  - **PLAY**: lasts exactly duration × BEAT_US cycles. `enable` = ~rest and `note` = the entry's note.
  - **GAP**: lasts exactly GAP_US cycles with `enable`=0 and `note` held. If GAP_US is 0, this state is skipped.
  - After GAP (or after PLAY when there is no gap): if `idx` = DEPTH-1, the song ends; otherwise `idx`+1 and go to FETCH.
- End of song: pulse `done` for one cycle, go to IDLE, drive `enable` to 0. `idx` holds its final value.
- `busy` is 1 in every state except IDLE.
- `start` while `busy` is high: ignored.
- `stop` in any non-IDLE state: go to IDLE on the next edge with `enable`=0, `busy`=0 and no `done` pulse.
- `start` and `stop` in the same cycle: `stop` wins.
- Counters:
  - The cycle counter is sized for max(BEAT_US, GAP_US) - 1.
  - The beat counter is 4 bits.
  - Both counters clear on every state entry.

## Timing
- `start` sampled at edge N in IDLE:
  - FETCH after edge N.
  - PLAY after edge N+1, with `enable`/`note` valid from edge N+1.
- Entry-to-entry period = 1 (FETCH) + duration × BEAT_US + GAP_US cycles.
- `done` is asserted in the cycle after the FETCH that sees the marker, or after the final GAP at DEPTH-1. `busy` falls on the same edge.
- `rst` forces all outputs to 0 immediately, without waiting for a clock edge.

## Configuration
- `MELODY_LOOP_EN` defined:
  - Adds the `loop_en` input.
  - At end of song with `loop_en`=1, go to FETCH with `idx`=0 instead of IDLE; no `done` pulse and `busy` stays 1.
  - If entry 0 is itself the end marker, end normally with `done`, so an empty table never spins.
- `MELODY_LOOP_EN` undefined: no `loop_en` port and no looping.

## Structure
- Package `melody_pkg` contains:
  - note code constants C3=0 … C4=7;
  - the entry field positions and widths;
  - the end-marker value;
  - the state enum (IDLE, FETCH, PLAY, GAP).
- Sub-module `beat_timer`: cycle counter with a restart input. It produces a one-cycle tick every BEAT_US cycles and a terminal pulse after GAP_US cycles.

## Test plan
All scenarios use BEAT_US=10 and GAP_US=2.
1. Table [0]=8'h52 (note 5, 2 beats), [1]=8'h00; `start` at cycle 0 → `enable`=1 with `note`=5 during cycles 2–21, then 0 during cycles 22–23; FETCH of entry 1; `done` pulse and `busy` falls at cycle 25.
2. Table [0]=8'hB3 (rest, 3 beats), [1]=0 → `enable` stays 0 for the whole song and `busy` is high for 1+30+2+1 cycles before `done`.
3. `stop` in the 5th cycle of PLAY → `enable`=0 and `busy`=0 on the next edge, no `done`; a following `start` restarts at `idx`=0.
4. All 16 entries at duration 1 → `idx` steps 0..15, then `done` at the end of the last GAP; simultaneous `start`+`stop` in IDLE leaves `busy`=0.
5. With `MELODY_LOOP_EN` and `loop_en`=1 → `idx` wraps from the marker back to 0 with no `done`. Clearing `loop_en` gives `done` at the next marker. A marker at entry 0 gives an immediate `done`.
6. Assert `rst` asynchronously mid-PLAY → `enable`, `busy` and `idx` read 0 before the next clock edge.

Source files
------------

// File: rtl/melody_pkg.sv
// Shared definitions for the melody sequencer: note codes, note-table entry layout and FSM states.
package melody_pkg;

    localparam logic [2:0] NOTE_C3 = 3'd0;
    localparam logic [2:0] NOTE_D3 = 3'd1;
    localparam logic [2:0] NOTE_E3 = 3'd2;
    localparam logic [2:0] NOTE_F3 = 3'd3;
    localparam logic [2:0] NOTE_G3 = 3'd4;
    localparam logic [2:0] NOTE_A3 = 3'd5;
    localparam logic [2:0] NOTE_B3 = 3'd6;
    localparam logic [2:0] NOTE_C4 = 3'd7;

    // Entry layout: [7] rest, [6:4] note, [3:0] duration in beats
    localparam int ENTRY_W  = 8;
    localparam int REST_BIT = 7;
    localparam int NOTE_LSB = 4;
    localparam int NOTE_W   = 3;
    localparam int DUR_LSB  = 0;
    localparam int DUR_W    = 4;

    localparam logic [DUR_W-1:0] END_MARKER = '0;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        PLAY,
        GAP
    } state_t;

endpackage

// File: rtl/melody_sequencer_beat_timer.sv
// Cycle counter for the melody sequencer: beat tick every BEAT_US cycles, gap terminal after GAP_US cycles.
module beat_timer #(
    parameter int BEAT_US = 125000,
    parameter int GAP_US  = 10000
) (
    input  logic clk_1MHz,
    input  logic rst,
    input  logic restart,
    input  logic gap_sel,
    output logic beat_tick,
    output logic gap_done
);

    localparam int CNT_MAX = ((BEAT_US > GAP_US) ? BEAT_US : GAP_US) - 1;
    localparam int CW      = (CNT_MAX > 0) ? $clog2(CNT_MAX + 1) : 1;
    localparam logic [CW-1:0] BEAT_LAST = CW'(BEAT_US - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'((GAP_US > 0) ? GAP_US - 1 : 0);

    logic [CW-1:0] cnt;

    assign beat_tick = (cnt == BEAT_LAST);
    assign gap_done  = (GAP_US > 0) && (cnt == GAP_LAST);

    // During a gap the counter must not wrap at the beat length, since the gap may be longer
    always_ff @(posedge clk_1MHz or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (restart || (beat_tick && !gap_sel)) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/melody_sequencer.sv
// Note-table driven melody player for the piezo tone generator.
// Optional MELODY_LOOP_EN adds a loop_en input that restarts the song at entry 0 instead of finishing.
module melody_sequencer
    import melody_pkg::*;
#(
    parameter int DEPTH   = 16,
    parameter int BEAT_US = 125000,
    parameter int GAP_US  = 10000,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic               clk_1MHz,
    input  logic               rst,
    input  logic               wr_en,
    input  logic [AW-1:0]      wr_addr,
    input  logic [ENTRY_W-1:0] wr_data,
    input  logic               start,
    input  logic               stop,
`ifdef MELODY_LOOP_EN
    input  logic               loop_en,
`endif
    output logic [NOTE_W-1:0]  note,
    output logic               enable,
    output logic               busy,
    output logic               done,
    output logic [AW-1:0]      idx
);

    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

    state_t state, state_next;

    logic [ENTRY_W-1:0] table_mem [DEPTH];
    logic [ENTRY_W-1:0] entry;
    logic [AW-1:0]      idx_next;
    logic               cur_rest;
    logic [DUR_W-1:0]   cur_dur;
    logic [DUR_W-1:0]   beat_cnt;
    logic               load;
    logic               advance;
    logic               end_song;
    logic               done_next;
    logic               restart;
    logic               beat_tick;
    logic               gap_done;
    logic               loop_ok;

`ifdef MELODY_LOOP_EN
    assign loop_ok = loop_en;
`else
    assign loop_ok = 1'b0;
`endif

    always_ff @(posedge clk_1MHz) begin
        if (wr_en) begin
            table_mem[wr_addr] <= wr_data;
        end
    end

    assign entry = table_mem[idx];

    beat_timer #(
        .BEAT_US (BEAT_US),
        .GAP_US  (GAP_US)
    ) u_beat_timer (
        .clk_1MHz  (clk_1MHz),
        .rst       (rst),
        .restart   (restart),
        .gap_sel   (state == GAP),
        .beat_tick (beat_tick),
        .gap_done  (gap_done)
    );

    always_comb begin
        state_next = state;
        idx_next   = idx;
        load       = 1'b0;
        advance    = 1'b0;
        end_song   = 1'b0;
        done_next  = 1'b0;

        case (state)
            IDLE: begin
                if (start && !stop) begin
                    state_next = FETCH;
                    idx_next   = '0;
                end
            end
            FETCH: begin
                if (stop) begin
                    state_next = IDLE;
                end else if (entry[DUR_LSB +: DUR_W] == END_MARKER) begin
                    end_song = 1'b1;
                end else begin
                    state_next = PLAY;
                    load       = 1'b1;
                end
            end
            PLAY: begin
                if (stop) begin
                    state_next = IDLE;
                end else if (beat_tick && (beat_cnt == cur_dur - 1'b1)) begin
                    if (GAP_US == 0) begin
                        advance = 1'b1;
                    end else begin
                        state_next = GAP;
                    end
                end
            end
            GAP: begin
                if (stop) begin
                    state_next = IDLE;
                end else if (gap_done) begin
                    advance = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase

        if (advance) begin
            if (idx == LAST_IDX) begin
                end_song = 1'b1;
            end else begin
                state_next = FETCH;
                idx_next   = idx + 1'b1;
            end
        end

        // A marker at entry 0 always finishes, so an empty table cannot loop forever
        if (end_song) begin
            if (loop_ok && !(state == FETCH && idx == '0)) begin
                state_next = FETCH;
                idx_next   = '0;
            end else begin
                state_next = IDLE;
                done_next  = 1'b1;
            end
        end
    end

    assign restart = (state_next != state);

    always_ff @(posedge clk_1MHz or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            idx      <= '0;
            note     <= '0;
            done     <= 1'b0;
            beat_cnt <= '0;
        end else begin
            state <= state_next;
            idx   <= idx_next;
            done  <= done_next;
            if (load) begin
                note <= entry[NOTE_LSB +: NOTE_W];
            end
            if (restart) begin
                beat_cnt <= '0;
            end else if (beat_tick) begin
                beat_cnt <= beat_cnt + 1'b1;
            end
        end
    end

    // Rest flag and duration only matter once PLAY has been entered through FETCH
    always_ff @(posedge clk_1MHz) begin
        if (load) begin
            cur_rest <= entry[REST_BIT];
            cur_dur  <= entry[DUR_LSB +: DUR_W];
        end
    end

    assign enable = (state == PLAY) && !cur_rest;
    assign busy   = (state != IDLE);

endmodule

// File: tb/tb_melody_sequencer.sv
// Directed self-checking bench for melody_sequencer with BEAT_US=10, GAP_US=2.
`timescale 1ns/1ps
module tb_melody_sequencer;

    localparam int DEPTH = 16;
    localparam int BEAT  = 10;
    localparam int GAPC  = 2;

    logic       clk_1MHz = 1'b0;
    logic       rst      = 1'b1;
    logic       wr_en    = 1'b0;
    logic [3:0] wr_addr  = '0;
    logic [7:0] wr_data  = '0;
    logic       start    = 1'b0;
    logic       stop     = 1'b0;
`ifdef MELODY_LOOP_EN
    logic       loop_en  = 1'b0;
`endif
    logic [2:0] note;
    logic       enable;
    logic       busy;
    logic       done;
    logic [3:0] idx;

    int checks = 0;
    int errors = 0;

    logic       en_log   [256];
    logic       busy_log [256];
    logic       done_log [256];
    logic [3:0] idx_log  [256];
    logic [2:0] note_log [256];

    melody_sequencer #(
        .DEPTH   (DEPTH),
        .BEAT_US (BEAT),
        .GAP_US  (GAPC)
    ) dut (
        .clk_1MHz (clk_1MHz),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .start    (start),
        .stop     (stop),
`ifdef MELODY_LOOP_EN
        .loop_en  (loop_en),
`endif
        .note     (note),
        .enable   (enable),
        .busy     (busy),
        .done     (done),
        .idx      (idx)
    );

    always #500 clk_1MHz = ~clk_1MHz;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic log_cycle(input int c);
        en_log[c]   = enable;
        busy_log[c] = busy;
        done_log[c] = done;
        idx_log[c]  = idx;
        note_log[c] = note;
    endtask

    task automatic write_entry(input int a, input logic [7:0] d);
        wr_en   = 1'b1;
        wr_addr = 4'(a);
        wr_data = d;
        @(negedge clk_1MHz);
        wr_en   = 1'b0;
    endtask

    // start is high through the rest of cycle 0; cycle c is logged at the negedge after edge c
    task automatic run_song(input int ncyc, input int stop_at);
        start = 1'b1;
        for (int c = 1; c <= ncyc; c++) begin
            @(negedge clk_1MHz);
            log_cycle(c);
            start = 1'b0;
            stop  = (c == stop_at);
        end
        stop = 1'b0;
    endtask

    function automatic int count_done(input int lo, input int hi);
        int n = 0;
        for (int i = lo; i <= hi; i++) n += int'(done_log[i]);
        return n;
    endfunction

    function automatic int count_en(input int lo, input int hi);
        int n = 0;
        for (int i = lo; i <= hi; i++) n += int'(en_log[i]);
        return n;
    endfunction

    initial begin
        #10;
        check("rst_enable", 32'(enable), 0);
        check("rst_busy",   32'(busy),   0);
        check("rst_done",   32'(done),   0);
        check("rst_idx",    32'(idx),    0);
        check("rst_note",   32'(note),   0);
        @(negedge clk_1MHz);
        @(negedge clk_1MHz);
        rst = 1'b0;

        // Single 2-beat note followed by the end marker
        write_entry(0, 8'h52);
        write_entry(1, 8'h00);
        run_song(27, 0);
        check("s1_fetch_busy",  32'(busy_log[1]), 1);
        check("s1_fetch_en",    32'(en_log[1]),   0);
        check("s1_play_first",  32'(en_log[2]),   1);
        check("s1_note",        32'(note_log[2]), 5);
        check("s1_play_count",  32'(count_en(2, 21)), 20);
        check("s1_gap_en",      32'(count_en(22, 27)), 0);
        check("s1_gap_note",    32'(note_log[23]), 5);
        check("s1_fetch1_busy", 32'(busy_log[24]), 1);
        check("s1_fetch1_idx",  32'(idx_log[24]),  1);
        check("s1_done_early",  32'(count_done(1, 24)), 0);
        check("s1_done",        32'(done_log[25]), 1);
        check("s1_busy_fall",   32'(busy_log[25]), 0);
        check("s1_done_width",  32'(done_log[26]), 0);
        check("s1_idx_hold",    32'(idx_log[26]),  1);

        // Rest entry: silent for the whole song
        write_entry(0, 8'hB3);
        write_entry(1, 8'h00);
        run_song(37, 0);
        check("s2_en_never",   32'(count_en(1, 37)), 0);
        check("s2_busy_first", 32'(busy_log[1]),  1);
        check("s2_busy_last",  32'(busy_log[34]), 1);
        check("s2_done_early", 32'(done_log[34]), 0);
        check("s2_done",       32'(done_log[35]), 1);
        check("s2_busy_fall",  32'(busy_log[35]), 0);

        // Full table of 1-beat notes, no marker
        for (int k = 0; k < DEPTH; k++) write_entry(k, {1'b0, 3'(k), 4'd1});
        run_song(212, 0);
        for (int k = 0; k < DEPTH; k++) check($sformatf("s4_idx%0d", k), 32'(idx_log[1 + 13 * k]), k);
        check("s4_note9",      32'(note_log[119]), 1);
        check("s4_en9",        32'(en_log[119]),   1);
        check("s4_last_gap",   32'(busy_log[208]), 1);
        check("s4_done_early", 32'(count_done(1, 208)), 0);
        check("s4_done",       32'(done_log[209]), 1);
        check("s4_busy_fall",  32'(busy_log[209]), 0);
        check("s4_idx_final",  32'(idx_log[210]),  15);

        // Abort in the 5th PLAY cycle of entry 2
        run_song(60, 32);
        check("s3_pre_en",    32'(en_log[32]),   1);
        check("s3_pre_idx",   32'(idx_log[32]),  2);
        check("s3_stop_en",   32'(en_log[33]),   0);
        check("s3_stop_busy", 32'(busy_log[33]), 0);
        check("s3_no_done",   32'(count_done(33, 60)), 0);
        run_song(5, 3);
        check("s3_restart_idx", 32'(idx_log[1]),  0);
        check("s3_restart_en",  32'(en_log[2]),   1);
        check("s3_restart_stop", 32'(busy_log[4]), 0);

        // start and stop together in IDLE
        start = 1'b1;
        stop  = 1'b1;
        @(negedge clk_1MHz);
        start = 1'b0;
        stop  = 1'b0;
        check("s4_start_stop_busy", 32'(busy), 0);
        @(negedge clk_1MHz);
        check("s4_start_stop_busy2", 32'(busy), 0);

        // Asynchronous reset in the middle of entry 1 PLAY
        run_song(16, 0);
        check("s6_pre_busy", 32'(busy), 1);
        check("s6_pre_idx",  32'(idx),  1);
        check("s6_pre_en",   32'(enable), 1);
        #100;
        rst = 1'b1;
        #10;
        check("s6_rst_en",   32'(enable), 0);
        check("s6_rst_busy", 32'(busy),   0);
        check("s6_rst_idx",  32'(idx),    0);
        check("s6_rst_note", 32'(note),   0);
        @(negedge clk_1MHz);
        rst = 1'b0;
        @(negedge clk_1MHz);
        check("s6_after_busy", 32'(busy), 0);

`ifdef MELODY_LOOP_EN
        // Looping song, loop cleared during the second pass
        write_entry(0, 8'h31);
        write_entry(1, 8'h00);
        loop_en = 1'b1;
        start   = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk_1MHz);
            log_cycle(c);
            start = 1'b0;
            if (c == 20) loop_en = 1'b0;
        end
        check("s5_marker_idx", 32'(idx_log[14]),  1);
        check("s5_wrap_idx",   32'(idx_log[15]),  0);
        check("s5_wrap_busy",  32'(busy_log[15]), 1);
        check("s5_wrap_en",    32'(en_log[16]),   1);
        check("s5_no_done",    32'(count_done(1, 28)), 0);
        check("s5_done",       32'(done_log[29]), 1);
        check("s5_busy_fall",  32'(busy_log[29]), 0);

        write_entry(0, 8'h00);
        loop_en = 1'b1;
        run_song(4, 0);
        check("s5_empty_fetch", 32'(busy_log[1]), 1);
        check("s5_empty_done",  32'(done_log[2]), 1);
        check("s5_empty_busy",  32'(busy_log[2]), 0);
        check("s5_empty_idle",  32'(busy_log[4]), 0);
        loop_en = 1'b0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
